rgb_to_gray_stream: RTL
=======================

Name: rgb_to_gray_stream

Overview:
AXI4-Stream RGB888-to-8-bit-luminance converter. It sits directly upstream of the black/white threshold filter and feeds it grey pixels.
Three-stage pipeline with per-stage valid/ready handshaking. Frame sideband (tuser = SOF, tlast = EOF) passes through unchanged.
An output-side frame monitor counts pixels and frames and flags malformed frames.

Parameters:
COEF_R, 77, red weight (Q0.8); COEF_R+COEF_G+COEF_B must equal 256 (elaboration-time check)
COEF_G, 150, green weight (Q0.8)
COEF_B, 29, blue weight (Q0.8)
FRAME_PIXELS, 307200, expected beats per frame (640x480)
CNT_W, 20, width of pixel counter; must satisfy 2^CNT_W > FRAME_PIXELS
FCNT_W, 16, width of frame counter

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
s_axis_tdata  in  24  pixel: [23:16]=R, [15:8]=G, [7:0]=B
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input beat accepted when high with tvalid
s_axis_tuser  in  1  start of frame
s_axis_tlast  in  1  end of frame
m_axis_tdata  out  8  luminance Y
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream (threshold filter) ready
m_axis_tuser  out  1  SOF, delayed with its pixel
m_axis_tlast  out  1  EOF, delayed with its pixel
gray_bypass  in  1  1: Y = G channel (sampled per beat at stage 1)
err_clr  in  1  single-cycle clear of frame_err
frame_count  out  FCNT_W  frames completed (output side), wraps modulo 2^FCNT_W
last_frame_pixels  out  CNT_W  beat count of most recent completed frame
frame_err  out  1  sticky malformed-frame flag

Behaviour:
- Reset values (async assert, sync release):
  - all stage valids 0, m_axis_tvalid 0, m_axis_tdata/tuser/tlast 0
  - frame_count 0, last_frame_pixels 0, frame_err 0, internal pixel counter 0
- Stage 1: register products pR=R*COEF_R, pG=G*COEF_G, pB=B*COEF_B (16 bit each). Also register tuser, tlast and bypass, plus G for the bypass path.
- Stage 2: sum = pR+pG+pB+128 (17 bit); y = sum[15:8]; clamp to 255 if sum[16] set (unreachable with legal coefficients, but required). With bypass set, y = G.
- Stage 3: output register drives the m_axis_* signals.
- Latency: 3 cycles from input acceptance to m_axis_tvalid with no backpressure. Throughput: 1 pixel/cycle.
- Handshake:
  - stage k loads when ready_k = !valid_k || ready_(k+1), where ready_4 = m_axis_tready
  - s_axis_tready = ready_1
  - bubbles collapse
  - m_axis_* held stable while tvalid=1 and tready=0
  - no beat is dropped or duplicated
- Frame monitor, acting on output handshakes (m_axis_tvalid && m_axis_tready):
  - pixel counter increments per beat, saturating at 2^CNT_W-1
  - beat with tuser=1 while counter!=0: frame_err set; counter restarts at 1
  - beat with tlast=1: last_frame_pixels <= counter+1 (saturating); frame_count++; counter <= 0
  - frame_err also set if that tlast total != FRAME_PIXELS
  - tuser and tlast on the same beat form a legal 1-pixel frame; it is checked against FRAME_PIXELS
- err_clr clears frame_err. A simultaneous new error wins (frame_err stays 1).
- ARESET mid-frame: pipeline contents discarded and counters zeroed. The next beat is treated as frame start (no error raised for the truncated frame).

Decomposition:
- gray_pkg holds:
  - rgb_pix_t struct {r,g,b: 8 bit each}
  - default coefficient constants COEF_R_DEF/COEF_G_DEF/COEF_B_DEF, ROUND_C=128
  - Y_W=8
  - FRAME_PIXELS_DEF
- One sub-module: rgb2gray_frame_monitor. Inputs: output-handshake beat strobe, tuser, tlast, err_clr. Outputs: frame_count, last_frame_pixels, frame_err.
- Pipeline stays in the top module.

Test Plan:
- Single beats with m_axis_tready=1, each -> tdata exactly 3 cycles after acceptance:
  - (R,G,B)=(255,255,255) -> 255
  - (0,0,0) -> 0
  - (255,0,0) -> 77
  - (0,255,0) -> 149
  - (0,0,255) -> 29
  - (100,150,200) -> 141
- gray_bypass=1 with (10,200,30) -> 200. Toggling bypass on alternate beats -> each beat follows its own sampled bypass.
- Random backpressure (m_axis_tready 50% random, tvalid 70% random) over 1000 beats -> output stream equals reference model in order; no loss/dup; m_axis_* stable while stalled.
- FRAME_PIXELS=16 override:
  - SOF+15 beats+EOF (16 total) -> frame_count=1, last_frame_pixels=16, frame_err=0
  - then a 12-beat frame -> last_frame_pixels=12, frame_err=1
  - err_clr -> frame_err=0
- tuser at beat 5 of a frame -> frame_err=1. Assert err_clr on the same cycle as a second bad tlast -> frame_err remains 1.
- Assert ARESET with 3 beats in flight and m_axis_tready=0 -> all valids/counters 0 next edge. A following clean 16-beat frame -> frame_count=1, frame_err=0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and defaults for the RGB888-to-luminance stream converter.
package gray_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_pix_t;

    localparam int unsigned COEF_R_DEF       = 77;
    localparam int unsigned COEF_G_DEF       = 150;
    localparam int unsigned COEF_B_DEF       = 29;
    localparam int unsigned ROUND_C          = 128;
    localparam int unsigned Y_W              = 8;
    localparam int unsigned FRAME_PIXELS_DEF = 307200;

endpackage

// File: rtl/rgb_to_gray_stream_if.sv
// AXI4-Stream bundle (tdata/tvalid/tready/tuser/tlast) with master/slave views.
interface rgb_to_gray_stream_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/rgb2gray_frame_monitor.sv
// Output-side frame monitor: counts beats and frames, flags malformed frames.
module rgb2gray_frame_monitor
    import gray_pkg::*;
#(
    parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned FCNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat,
    input  logic              sof,
    input  logic              eof,
    input  logic              err_clr,
    output logic [FCNT_W-1:0] frame_count,
    output logic [CNT_W-1:0]  last_frame_pixels,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if ((64'(1) << CNT_W) <= 64'(FRAME_PIXELS)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for FRAME_PIXELS");
    end

    logic [CNT_W-1:0]  cnt_q, cnt_d, base, inc;
    logic [CNT_W-1:0]  last_q, last_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              err_q, err_d, new_err;

    always_comb begin
        cnt_d   = cnt_q;
        last_d  = last_q;
        fcnt_d  = fcnt_q;
        new_err = 1'b0;
        base    = cnt_q;
        inc     = '0;
        if (beat) begin
            // An SOF inside a running frame starts a fresh frame at this beat.
            if (sof && cnt_q != '0) begin
                new_err = 1'b1;
                base    = '0;
            end
            inc = (base == CNT_MAX) ? CNT_MAX : base + CNT_W'(1);
            if (eof) begin
                last_d = inc;
                fcnt_d = fcnt_q + FCNT_W'(1);
                cnt_d  = '0;
                if (inc != CNT_W'(FRAME_PIXELS)) new_err = 1'b1;
            end else begin
                cnt_d = inc;
            end
        end
        err_d = new_err | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            last_q <= '0;
            fcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
            fcnt_q <= fcnt_d;
            err_q  <= err_d;
        end
    end

    assign frame_count       = fcnt_q;
    assign last_frame_pixels = last_q;
    assign frame_err         = err_q;

endmodule

// File: rtl/rgb_to_gray_stream.sv
// Three-stage AXI4-Stream RGB888 to 8-bit luminance converter with frame monitor.
module rgb_to_gray_stream
    import gray_pkg::*;
#(
    parameter int unsigned COEF_R       = COEF_R_DEF,
    parameter int unsigned COEF_G       = COEF_G_DEF,
    parameter int unsigned COEF_B       = COEF_B_DEF,
    parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned FCNT_W       = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    rgb_to_gray_stream_if.slave   s_axis,
    rgb_to_gray_stream_if.master  m_axis,
    input  logic                  gray_bypass,
    input  logic                  err_clr,
    output logic [FCNT_W-1:0]     frame_count,
    output logic [CNT_W-1:0]      last_frame_pixels,
    output logic                  frame_err
);

    if (COEF_R + COEF_G + COEF_B != 256) begin : g_bad_coef
        $error("COEF_R + COEF_G + COEF_B must equal 256");
    end

    rgb_pix_t       pix;
    logic           ready1, ready2, ready3;
    logic           v1_q, v2_q, v3_q;
    logic [15:0]    p_r_q, p_g_q, p_b_q;
    logic [7:0]     g1_q;
    logic           user1_q, last1_q, byp1_q;
    logic [Y_W-1:0] y2_q, y2_d, y3_q;
    logic           user2_q, last2_q, user3_q, last3_q;
    logic [8:0]     sum_hi;

    assign pix    = rgb_pix_t'(s_axis.tdata);
    assign ready3 = !v3_q || m_axis.tready;
    assign ready2 = !v2_q || ready3;
    assign ready1 = !v1_q || ready2;
    assign s_axis.tready = ready1;

    always_comb begin
        // Rounded sum shifted down by 8; bit 8 flags overflow past 255.
        sum_hi = 9'((17'(p_r_q) + 17'(p_g_q) + 17'(p_b_q) + 17'(ROUND_C)) >> 8);
        if (byp1_q)         y2_d = g1_q;
        else if (sum_hi[8]) y2_d = '1;
        else                y2_d = sum_hi[7:0];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            p_r_q   <= '0;
            p_g_q   <= '0;
            p_b_q   <= '0;
            g1_q    <= '0;
            user1_q <= 1'b0;
            last1_q <= 1'b0;
            byp1_q  <= 1'b0;
            y2_q    <= '0;
            user2_q <= 1'b0;
            last2_q <= 1'b0;
            y3_q    <= '0;
            user3_q <= 1'b0;
            last3_q <= 1'b0;
        end else begin
            if (ready1) v1_q <= s_axis.tvalid;
            if (ready1 && s_axis.tvalid) begin
                p_r_q   <= 16'(pix.r) * 16'(COEF_R);
                p_g_q   <= 16'(pix.g) * 16'(COEF_G);
                p_b_q   <= 16'(pix.b) * 16'(COEF_B);
                g1_q    <= pix.g;
                user1_q <= s_axis.tuser;
                last1_q <= s_axis.tlast;
                byp1_q  <= gray_bypass;
            end
            if (ready2) v2_q <= v1_q;
            if (ready2 && v1_q) begin
                y2_q    <= y2_d;
                user2_q <= user1_q;
                last2_q <= last1_q;
            end
            if (ready3) v3_q <= v2_q;
            if (ready3 && v2_q) begin
                y3_q    <= y2_q;
                user3_q <= user2_q;
                last3_q <= last2_q;
            end
        end
    end

    assign m_axis.tvalid = v3_q;
    assign m_axis.tdata  = y3_q;
    assign m_axis.tuser  = user3_q;
    assign m_axis.tlast  = last3_q;

    rgb2gray_frame_monitor #(
        .FRAME_PIXELS (FRAME_PIXELS),
        .CNT_W        (CNT_W),
        .FCNT_W       (FCNT_W)
    ) u_frame_monitor (
        .clk               (ACLK),
        .rst               (ARESET),
        .beat              (m_axis.tvalid && m_axis.tready),
        .sof               (m_axis.tuser),
        .eof               (m_axis.tlast),
        .err_clr           (err_clr),
        .frame_count       (frame_count),
        .last_frame_pixels (last_frame_pixels),
        .frame_err         (frame_err)
    );

endmodule
